// File: rtl/save_pc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : save_pc_pkg
//  Description : Core-wide constants shared by the single-cycle RISC-V core:
//                the architectural register width and the boot address.
//  Revision    : 1.0 - initial release
// ============================================================================
package save_pc_pkg;

    // Architectural register width (XLEN).
    localparam int          c_xlen      = 32;

    // Address the PC takes while reset is held. Execution starts here.
    localparam logic [31:0] c_boot_addr = 32'h0000_0000;

endpackage : save_pc_pkg
`default_nettype wire

// File: rtl/save_pc.sv
`default_nettype none
// ============================================================================
//  Module      : save_pc
//  Description : Program-counter state register. Captures the next PC from
//                the next-PC mux on every rising clock edge. It also keeps a
//                valid flag and a misalignment flag for the captured value.
//
//  Ports       : CLK           - system clock, rising-edge active
//                RST           - synchronous reset, active low
//                PC_In         - next PC (WIDTH bits)
//                PC_Out        - registered current PC (WIDTH bits)
//                PC_Valid      - 0 while in reset, 1 after the first load
//                PC_Misaligned - 1 when the captured PC has PC[1:0] != 0
//
//  Revision    : 1.0 - initial release
// ============================================================================
module save_pc
    import save_pc_pkg::*;
#(
    parameter int               WIDTH       = c_xlen,
    parameter logic [WIDTH-1:0] RESET_VALUE = WIDTH'(c_boot_addr)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] PC_In,
    output logic [WIDTH-1:0] PC_Out,
    output logic             PC_Valid,
    output logic             PC_Misaligned
);

    // The reset value's alignment is fixed at elaboration time.
    localparam logic c_reset_misaligned = (RESET_VALUE[1:0] != 2'b00);

    logic [WIDTH-1:0] r_pc;
    logic             r_valid;
    logic             r_misaligned;

    // The register loads on every edge: there is no enable or stall.
    // Reset takes priority over the load.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_pc         <= RESET_VALUE;
            r_valid      <= 1'b0;
            r_misaligned <= c_reset_misaligned;
        end else begin
            r_pc         <= PC_In;
            r_valid      <= 1'b1;
            r_misaligned <= (PC_In[1:0] != 2'b00);
        end
    end

    assign PC_Out        = r_pc;
    assign PC_Valid      = r_valid;
    assign PC_Misaligned = r_misaligned;

endmodule : save_pc
`default_nettype wire

// File: tb/tb_save_pc.sv
`default_nettype none
// ============================================================================
//  Module      : tb_save_pc
//  Description : Self-checking bench for save_pc. A reference model tracks
//                the outputs expected from the last sampled edge. Directed
//                steps also pin hand-computed literals.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_save_pc;

    localparam logic [31:0] c_rst_val = 32'h0000_0000;

    logic        CLK;
    logic        RST;
    logic [31:0] PC_In;
    logic [31:0] PC_Out;
    logic        PC_Valid;
    logic        PC_Misaligned;

    int total = 0;
    int bad   = 0;

    save_pc #(
        .WIDTH       (32),
        .RESET_VALUE (c_rst_val)
    ) u_dut (
        .CLK           (CLK),
        .RST           (RST),
        .PC_In         (PC_In),
        .PC_Out        (PC_Out),
        .PC_Valid      (PC_Valid),
        .PC_Misaligned (PC_Misaligned)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // ------------------------------------------------------------------
    // Reference model: whatever was present at the latest rising edge
    // decides the outputs until the next one.
    // ------------------------------------------------------------------
    logic [31:0] m_pc;
    logic        m_valid;
    logic        m_mis;
    logic        m_seen = 1'b0;

    always @(posedge CLK) begin
        m_seen = 1'b1;
        if (RST === 1'b0) begin
            m_pc    = c_rst_val;
            m_valid = 1'b0;
        end else begin
            m_pc    = PC_In;
            m_valid = 1'b1;
        end
        m_mis = (m_pc % 4) != 0;
    end

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h at t=%0t", name, got, exp, $time);
        end
    endtask

    // Compare every cycle, mid-period, once an edge has defined the outputs.
    always @(negedge CLK) begin
        if (m_seen) begin
            chk("model_pc",    PC_Out,               m_pc);
            chk("model_valid", {31'd0, PC_Valid},      {31'd0, m_valid});
            chk("model_mis",   {31'd0, PC_Misaligned}, {31'd0, m_mis});
        end
    end

    // Drive inputs just after a falling edge, then settle past the rising one.
    task automatic apply(input logic r, input logic [31:0] v);
        @(negedge CLK);
        RST   = r;
        PC_In = v;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RST   = 1'b0;
        PC_In = 32'h40;

        // Reset
        @(posedge CLK); #1;
        chk("reset_pc",    PC_Out,               32'h0);
        chk("reset_valid", {31'd0, PC_Valid},      32'h0);
        chk("reset_mis",   {31'd0, PC_Misaligned}, 32'h0);

        // Sequential load, with a hold check between edges.
        apply(1'b1, 32'h0);
        chk("seq_0", PC_Out, 32'h0);
        chk("seq_valid", {31'd0, PC_Valid}, 32'h1);
        @(negedge CLK);
        PC_In = 32'h4;
        #2;
        chk("seq_hold", PC_Out, 32'h0);
        @(posedge CLK); #1;
        chk("seq_4", PC_Out, 32'h4);
        apply(1'b1, 32'h8);
        chk("seq_8", PC_Out, 32'h8);
        apply(1'b1, 32'hC);
        chk("seq_c", PC_Out, 32'hC);

        // Reset mid-run, then release.
        apply(1'b0, 32'h10);
        chk("mid_rst_pc",    PC_Out,          32'h0);
        chk("mid_rst_valid", {31'd0, PC_Valid}, 32'h0);
        apply(1'b1, 32'h10);
        chk("release_pc",    PC_Out,          32'h10);
        chk("release_valid", {31'd0, PC_Valid}, 32'h1);

        // Glitches on PC_In between edges.
        @(negedge CLK);
        PC_In = 32'h100; #1;
        PC_In = 32'h204; #1;
        PC_In = 32'h333; #1;
        chk("glitch_hold", PC_Out, 32'h10);
        PC_In = 32'h500;
        @(posedge CLK); #1;
        chk("glitch_load", PC_Out, 32'h500);

        // A reset pulse that does not span an edge is ignored.
        @(negedge CLK);
        PC_In = 32'h600;
        RST   = 1'b0; #1;
        RST   = 1'b1;
        @(posedge CLK); #1;
        chk("rst_pulse_pc",    PC_Out,          32'h600);
        chk("rst_pulse_valid", {31'd0, PC_Valid}, 32'h1);

        // Alignment flag.
        apply(1'b1, 32'h6);
        chk("mis_6", {31'd0, PC_Misaligned}, 32'h1);
        apply(1'b1, 32'h8);
        chk("mis_8", {31'd0, PC_Misaligned}, 32'h0);
        apply(1'b1, 32'h3);
        chk("mis_3", {31'd0, PC_Misaligned}, 32'h1);
        apply(1'b0, 32'h7);
        chk("mis_rst", {31'd0, PC_Misaligned}, 32'h0);
        chk("mis_rst_pc", PC_Out, 32'h0);

        // Extremes.
        apply(1'b1, 32'hFFFF_FFFC);
        chk("ext_max", PC_Out, 32'hFFFF_FFFC);
        apply(1'b1, 32'h0);
        chk("ext_zero", PC_Out, 32'h0);
        apply(1'b1, 32'hA5A5_5A5A);
        chk("ext_pattern", PC_Out, 32'hA5A5_5A5A);

        @(negedge CLK); #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1);
    end

endmodule : tb_save_pc
`default_nettype wire
